// File: rtl/id_stage_pipelined_pkg.sv
// ARM decode definitions: mode/opcode/ALU command encodings, condition codes,
// and the decode and condition-check functions used by the ID stage.
package arm_pkg;

  localparam logic [1:0] MODE_ALU = 2'b00;
  localparam logic [1:0] MODE_MEM = 2'b01;
  localparam logic [1:0] MODE_BR  = 2'b10;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;

  localparam logic [3:0] EXE_NOP = 4'd0;
  localparam logic [3:0] EXE_MOV = 4'd1;
  localparam logic [3:0] EXE_ADD = 4'd2;
  localparam logic [3:0] EXE_ADC = 4'd3;
  localparam logic [3:0] EXE_SUB = 4'd4;
  localparam logic [3:0] EXE_SBC = 4'd5;
  localparam logic [3:0] EXE_AND = 4'd6;
  localparam logic [3:0] EXE_ORR = 4'd7;
  localparam logic [3:0] EXE_EOR = 4'd8;
  localparam logic [3:0] EXE_MVN = 4'd9;

  typedef enum logic [3:0] {
    COND_EQ, COND_NE, COND_CS, COND_CC, COND_MI, COND_PL, COND_VS, COND_VC,
    COND_HI, COND_LS, COND_GE, COND_LT, COND_GT, COND_LE, COND_AL, COND_NV
  } cond_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef struct packed {
    logic       wb_en;
    logic       mem_r_en;
    logic       mem_w_en;
    logic       b;
    logic       s;
    logic       imm;
    logic [3:0] exe_cmd;
    logic       uses_src1;
    logic       two_src;
    logic       is_str;
  } dec_t;

  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v, res;
    n = nzcv[FLAG_N];
    z = nzcv[FLAG_Z];
    c = nzcv[FLAG_C];
    v = nzcv[FLAG_V];
    case (cond_e'(cond))
      COND_EQ: res = z;
      COND_NE: res = !z;
      COND_CS: res = c;
      COND_CC: res = !c;
      COND_MI: res = n;
      COND_PL: res = !n;
      COND_VS: res = v;
      COND_VC: res = !v;
      COND_HI: res = c && !z;
      COND_LS: res = !c || z;
      COND_GE: res = (n == v);
      COND_LT: res = (n != v);
      COND_GT: res = !z && (n == v);
      COND_LE: res = z || (n != v);
      COND_AL: res = 1'b1;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  function automatic dec_t decode(input logic [31:0] instr);
    dec_t       d;
    logic [3:0] op;
    logic       s;
    d  = '0;
    op = instr[24:21];
    s  = instr[20];
    case (instr[27:26])
      MODE_ALU: begin
        d.uses_src1 = !(op == OP_MOV || op == OP_MVN);
        d.two_src   = !instr[25];
        d.wb_en     = 1'b1;
        d.s         = s;
        d.imm       = instr[25];
        case (op)
          OP_MOV:  d.exe_cmd = EXE_MOV;
          OP_MVN:  d.exe_cmd = EXE_MVN;
          OP_ADD:  d.exe_cmd = EXE_ADD;
          OP_ADC:  d.exe_cmd = EXE_ADC;
          OP_SUB:  d.exe_cmd = EXE_SUB;
          OP_SBC:  d.exe_cmd = EXE_SBC;
          OP_AND:  d.exe_cmd = EXE_AND;
          OP_ORR:  d.exe_cmd = EXE_ORR;
          OP_EOR:  d.exe_cmd = EXE_EOR;
          OP_CMP:  begin d.exe_cmd = EXE_SUB; d.wb_en = 1'b0; end
          OP_TST:  begin d.exe_cmd = EXE_AND; d.wb_en = 1'b0; end
          default: begin d.wb_en = 1'b0; d.s = 1'b0; d.imm = 1'b0; end
        endcase
      end
      MODE_MEM: begin
        d.uses_src1 = 1'b1;
        d.exe_cmd   = EXE_ADD;
        d.imm       = instr[25];
        if (s) begin
          d.mem_r_en = 1'b1;
          d.wb_en    = 1'b1;
        end else begin
          d.mem_w_en = 1'b1;
          d.two_src  = 1'b1;
          d.is_str   = 1'b1;
        end
      end
      MODE_BR: d.b = 1'b1;
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/id_stage_pipelined_if.sv
// Signal bundle between the ID stage and its surroundings (IF/ID, WB, hazard
// sources, and the ID/EX outputs).
interface id_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 4
);
  logic              in_valid;
  logic [DATA_W-1:0] pc_in;
  logic [31:0]       instr;
  logic [3:0]        status;
  logic              stall_in;
  logic              flush;
  logic              wb_en;
  logic [REG_AW-1:0] wb_dest;
  logic [DATA_W-1:0] wb_data;
  logic              exe_wb_en;
  logic              mem_wb_en;
  logic [REG_AW-1:0] exe_dest;
  logic [REG_AW-1:0] mem_dest;

  logic              hazard_o;
  logic              out_valid;
  logic              wb_en_o;
  logic              mem_r_en_o;
  logic              mem_w_en_o;
  logic              b_o;
  logic              s_o;
  logic              imm_o;
  logic [3:0]        exe_cmd_o;
  logic [DATA_W-1:0] val_rn_o;
  logic [DATA_W-1:0] val_rm_o;
  logic [REG_AW-1:0] dest_o;
  logic [REG_AW-1:0] src1_o;
  logic [REG_AW-1:0] src2_o;
  logic [11:0]       shift_op_o;
  logic [23:0]       imm24_o;
  logic [DATA_W-1:0] pc_o;

  modport slave (
    input  in_valid, pc_in, instr, status, stall_in, flush, wb_en, wb_dest, wb_data,
           exe_wb_en, mem_wb_en, exe_dest, mem_dest,
    output hazard_o, out_valid, wb_en_o, mem_r_en_o, mem_w_en_o, b_o, s_o, imm_o,
           exe_cmd_o, val_rn_o, val_rm_o, dest_o, src1_o, src2_o, shift_op_o, imm24_o, pc_o
  );

  modport master (
    output in_valid, pc_in, instr, status, stall_in, flush, wb_en, wb_dest, wb_data,
           exe_wb_en, mem_wb_en, exe_dest, mem_dest,
    input  hazard_o, out_valid, wb_en_o, mem_r_en_o, mem_w_en_o, b_o, s_o, imm_o,
           exe_cmd_o, val_rn_o, val_rm_o, dest_o, src1_o, src2_o, shift_op_o, imm24_o, pc_o
  );
endinterface

// File: rtl/id_stage_pipelined_reg_file.sv
// Register file: two combinational read ports, one write port on posedge.
// Entry i resets to i; optional same-cycle write-to-read bypass.
module reg_file #(
  parameter int DATA_W    = 32,
  parameter int REG_AW    = 4,
  parameter int WB_BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en_i,
  input  logic [REG_AW-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [REG_AW-1:0] rd_addr1_i,
  input  logic [REG_AW-1:0] rd_addr2_i,
  output logic [DATA_W-1:0] rd_data1_o,
  output logic [DATA_W-1:0] rd_data2_o
);
  localparam int DEPTH = 1 << REG_AW;

  logic [DEPTH-1:0][DATA_W-1:0] regs_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= DATA_W'(i);
    end else if (wr_en_i) begin
      regs_q[wr_addr_i] <= wr_data_i;
    end
  end

  always_comb begin
    rd_data1_o = regs_q[rd_addr1_i];
    rd_data2_o = regs_q[rd_addr2_i];
    if (WB_BYPASS != 0 && wr_en_i) begin
      if (wr_addr_i == rd_addr1_i) rd_data1_o = wr_data_i;
      if (wr_addr_i == rd_addr2_i) rd_data2_o = wr_data_i;
    end
  end
endmodule

// File: rtl/id_stage_pipelined.sv
// ARM decode stage with integrated ID/EX register: decode, condition check,
// register read, RAW hazard detection, and stall/bubble/flush control.
module id_stage_pipelined
  import arm_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int REG_AW    = 4,
  parameter int WB_BYPASS = 1
) (
  input logic       clk,
  input logic       rst,
  id_stage_if.slave io
);
  typedef struct packed {
    logic              valid;
    logic              wb_en;
    logic              mem_r_en;
    logic              mem_w_en;
    logic              b;
    logic              s;
    logic              imm;
    logic [3:0]        exe_cmd;
    logic [DATA_W-1:0] val_rn;
    logic [DATA_W-1:0] val_rm;
    logic [REG_AW-1:0] dest;
    logic [REG_AW-1:0] src1;
    logic [REG_AW-1:0] src2;
    logic [11:0]       shift_op;
    logic [23:0]       imm24;
    logic [DATA_W-1:0] pc;
  } idex_t;

  dec_t              dec;
  logic              cond_ok;
  logic [REG_AW-1:0] src1, src2;
  logic [DATA_W-1:0] rn_val, rm_val;
  logic              raw1, raw2, hazard;
  idex_t             idex_d, bubble_d, idex_q;

  assign dec     = decode(io.instr);
  assign cond_ok = cond_pass(io.instr[31:28], io.status);
  assign src1    = REG_AW'(io.instr[19:16]);
  // STR stores Rd, so its second operand comes from the destination field
  assign src2    = dec.is_str ? REG_AW'(io.instr[15:12]) : REG_AW'(io.instr[3:0]);

  reg_file #(
    .DATA_W    (DATA_W),
    .REG_AW    (REG_AW),
    .WB_BYPASS (WB_BYPASS)
  ) u_rf (
    .clk        (clk),
    .rst        (rst),
    .wr_en_i    (io.wb_en),
    .wr_addr_i  (io.wb_dest),
    .wr_data_i  (io.wb_data),
    .rd_addr1_i (src1),
    .rd_addr2_i (src2),
    .rd_data1_o (rn_val),
    .rd_data2_o (rm_val)
  );

  assign raw1 = (io.exe_wb_en && io.exe_dest == src1) || (io.mem_wb_en && io.mem_dest == src1);
  assign raw2 = (io.exe_wb_en && io.exe_dest == src2) || (io.mem_wb_en && io.mem_dest == src2);
  assign hazard = io.in_valid && cond_ok && ((dec.uses_src1 && raw1) || (dec.two_src && raw2));
  assign io.hazard_o = hazard;

  always_comb begin
    idex_d          = '0;
    idex_d.valid    = io.in_valid;
    idex_d.imm      = dec.imm;
    if (cond_ok) begin
      idex_d.wb_en    = dec.wb_en;
      idex_d.mem_r_en = dec.mem_r_en;
      idex_d.mem_w_en = dec.mem_w_en;
      idex_d.b        = dec.b;
      idex_d.s        = dec.s;
      idex_d.exe_cmd  = dec.exe_cmd;
    end
    idex_d.val_rn   = rn_val;
    idex_d.val_rm   = rm_val;
    idex_d.dest     = REG_AW'(io.instr[15:12]);
    idex_d.src1     = src1;
    idex_d.src2     = src2;
    idex_d.shift_op = io.instr[11:0];
    idex_d.imm24    = io.instr[23:0];
    idex_d.pc       = io.pc_in;

    // bubble keeps the data fields; only valid and controls are cleared
    bubble_d          = idex_d;
    bubble_d.valid    = 1'b0;
    bubble_d.wb_en    = 1'b0;
    bubble_d.mem_r_en = 1'b0;
    bubble_d.mem_w_en = 1'b0;
    bubble_d.b        = 1'b0;
    bubble_d.s        = 1'b0;
    bubble_d.imm      = 1'b0;
    bubble_d.exe_cmd  = EXE_NOP;
  end

  always_ff @(posedge clk) begin
    if (rst)                             idex_q <= '0;
    else if (io.flush)                   idex_q <= bubble_d;
    else if (io.stall_in)                idex_q <= idex_q;
    else if (hazard)                     idex_q <= bubble_d;
    else                                 idex_q <= idex_d;
  end

  assign io.out_valid  = idex_q.valid;
  assign io.wb_en_o    = idex_q.wb_en;
  assign io.mem_r_en_o = idex_q.mem_r_en;
  assign io.mem_w_en_o = idex_q.mem_w_en;
  assign io.b_o        = idex_q.b;
  assign io.s_o        = idex_q.s;
  assign io.imm_o      = idex_q.imm;
  assign io.exe_cmd_o  = idex_q.exe_cmd;
  assign io.val_rn_o   = idex_q.val_rn;
  assign io.val_rm_o   = idex_q.val_rm;
  assign io.dest_o     = idex_q.dest;
  assign io.src1_o     = idex_q.src1;
  assign io.src2_o     = idex_q.src2;
  assign io.shift_op_o = idex_q.shift_op;
  assign io.imm24_o    = idex_q.imm24;
  assign io.pc_o       = idex_q.pc;
endmodule

// File: tb/tb_id_stage_pipelined.sv
// Directed bench for id_stage_pipelined: decode table plus hazard, bypass,
// stall/flush and wide-parameter sequences.
module tb_id_stage_pipelined;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  id_stage_if #(.DATA_W(32), .REG_AW(4)) io  ();
  id_stage_if #(.DATA_W(16), .REG_AW(5)) io2 ();

  id_stage_pipelined #(.DATA_W(32), .REG_AW(4), .WB_BYPASS(1)) dut (
    .clk(clk), .rst(rst), .io(io));
  id_stage_pipelined #(.DATA_W(16), .REG_AW(5), .WB_BYPASS(1)) dut2 (
    .clk(clk), .rst(rst), .io(io2));

  logic        rf_we;
  logic [4:0]  rf_wa, rf_ra1, rf_ra2;
  logic [15:0] rf_wd, rf_rd1, rf_rd2;
  reg_file #(.DATA_W(16), .REG_AW(5), .WB_BYPASS(0)) u_rf (
    .clk(clk), .rst(rst), .wr_en_i(rf_we), .wr_addr_i(rf_wa), .wr_data_i(rf_wd),
    .rd_addr1_i(rf_ra1), .rd_addr2_i(rf_ra2), .rd_data1_o(rf_rd1), .rd_data2_o(rf_rd2));

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  status;
    logic [10:0] ctl;   // {valid, wb, mem_r, mem_w, b, s, imm, cmd[3:0]}
    logic [3:0]  rn, rm, d, s1, s2;
  } vec_t;

  localparam int NV = 24;
  vec_t v[NV];

  function automatic logic [31:0] alu(input logic [3:0] c, input logic i, input logic [3:0] op,
                                      input logic s, input logic [3:0] rn, input logic [3:0] rd,
                                      input logic [11:0] o2);
    return {c, 2'b00, i, op, s, rn, rd, o2};
  endfunction
  function automatic logic [31:0] mem(input logic [3:0] c, input logic l, input logic [3:0] rn,
                                      input logic [3:0] rd, input logic [11:0] off);
    return {c, 2'b01, 1'b0, 4'b1100, l, rn, rd, off};
  endfunction
  function automatic logic [31:0] br(input logic [3:0] c, input logic [23:0] off);
    return {c, 3'b101, 1'b0, off};
  endfunction
  function automatic logic [10:0] ct(input logic [5:0] f, input logic [3:0] cmd);
    return {1'b1, f, cmd};
  endfunction
  function automatic vec_t mkv(input logic [31:0] ins, input logic [3:0] st, input logic [10:0] c,
                               input logic [3:0] rn, input logic [3:0] rm, input logic [3:0] d,
                               input logic [3:0] s1, input logic [3:0] s2);
    vec_t r;
    r.instr = ins; r.status = st; r.ctl = c;
    r.rn = rn; r.rm = rm; r.d = d; r.s1 = s1; r.s2 = s2;
    return r;
  endfunction

  function automatic logic [10:0] ctl1();
    return {io.out_valid, io.wb_en_o, io.mem_r_en_o, io.mem_w_en_o, io.b_o, io.s_o,
            io.imm_o, io.exe_cmd_o};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [159:0] got, input logic [159:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  task automatic hz(input string nm, input logic [31:0] ins, input logic exp);
    io.instr = ins;
    #1;
    chk(nm, 160'(io.hazard_o), 160'(exp));
  endtask

  logic [31:0] add312;
  logic [31:0] pc;

  initial begin
    add312 = alu(4'hE, 1'b0, 4'h4, 1'b0, 4'h1, 4'h3, 12'h002);
    v[0]  = mkv(add312, 4'h0, ct(6'b100000, 4'h2), 4'h1, 4'h2, 4'h3, 4'h1, 4'h2);
    v[1]  = mkv(alu(4'hE, 1'b1, 4'hD, 1'b0, 4'h0, 4'h4, 12'h005), 4'h0, ct(6'b100001, 4'h1), 4'h0, 4'h5, 4'h4, 4'h0, 4'h5);
    v[2]  = mkv(alu(4'h0, 1'b0, 4'hD, 1'b0, 4'h0, 4'h6, 12'h002), 4'h0, ct(6'b000000, 4'h0), 4'h0, 4'h2, 4'h6, 4'h0, 4'h2);
    v[3]  = mkv(alu(4'h0, 1'b0, 4'hD, 1'b0, 4'h0, 4'h6, 12'h002), 4'h4, ct(6'b100000, 4'h1), 4'h0, 4'h2, 4'h6, 4'h0, 4'h2);
    v[4]  = mkv(alu(4'hE, 1'b0, 4'h2, 1'b1, 4'h1, 4'h4, 12'h002), 4'h0, ct(6'b100010, 4'h4), 4'h1, 4'h2, 4'h4, 4'h1, 4'h2);
    v[5]  = mkv(alu(4'hE, 1'b0, 4'hA, 1'b1, 4'h1, 4'h0, 12'h002), 4'h0, ct(6'b000010, 4'h4), 4'h1, 4'h2, 4'h0, 4'h1, 4'h2);
    v[6]  = mkv(alu(4'hE, 1'b1, 4'h8, 1'b1, 4'h3, 4'h0, 12'h007), 4'h0, ct(6'b000011, 4'h6), 4'h3, 4'h7, 4'h0, 4'h3, 4'h7);
    v[7]  = mkv(alu(4'hE, 1'b0, 4'hF, 1'b0, 4'h0, 4'h9, 12'h008), 4'h0, ct(6'b100000, 4'h9), 4'h0, 4'h8, 4'h9, 4'h0, 4'h8);
    v[8]  = mkv(alu(4'hE, 1'b0, 4'h5, 1'b0, 4'hB, 4'hA, 12'h00C), 4'h0, ct(6'b100000, 4'h3), 4'hB, 4'hC, 4'hA, 4'hB, 4'hC);
    v[9]  = mkv(alu(4'hE, 1'b0, 4'h6, 1'b0, 4'h2, 4'h1, 12'h003), 4'h0, ct(6'b100000, 4'h5), 4'h2, 4'h3, 4'h1, 4'h2, 4'h3);
    v[10] = mkv(alu(4'hE, 1'b0, 4'h0, 1'b0, 4'h3, 4'h2, 12'h004), 4'h0, ct(6'b100000, 4'h6), 4'h3, 4'h4, 4'h2, 4'h3, 4'h4);
    v[11] = mkv(alu(4'hE, 1'b0, 4'hC, 1'b0, 4'h6, 4'h5, 12'h007), 4'h0, ct(6'b100000, 4'h7), 4'h6, 4'h7, 4'h5, 4'h6, 4'h7);
    v[12] = mkv(alu(4'hE, 1'b0, 4'h1, 1'b0, 4'h9, 4'h8, 12'h00A), 4'h0, ct(6'b100000, 4'h8), 4'h9, 4'hA, 4'h8, 4'h9, 4'hA);
    v[13] = mkv(alu(4'hE, 1'b0, 4'h3, 1'b1, 4'h2, 4'h1, 12'h003), 4'h0, ct(6'b000000, 4'h0), 4'h2, 4'h3, 4'h1, 4'h2, 4'h3);
    v[14] = mkv(mem(4'hE, 1'b1, 4'h9, 4'h8, 12'h004), 4'h0, ct(6'b110000, 4'h2), 4'h9, 4'h4, 4'h8, 4'h9, 4'h4);
    v[15] = mkv(mem(4'hE, 1'b0, 4'h2, 4'h7, 12'h000), 4'h0, ct(6'b001000, 4'h2), 4'h2, 4'h7, 4'h7, 4'h2, 4'h7);
    v[16] = mkv(br(4'hE, 24'h000010), 4'h0, ct(6'b000100, 4'h0), 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    v[17] = mkv(alu(4'hF, 1'b0, 4'h4, 1'b0, 4'h1, 4'h3, 12'h002), 4'h0, ct(6'b000000, 4'h0), 4'h1, 4'h2, 4'h3, 4'h1, 4'h2);
    v[18] = mkv(alu(4'hC, 1'b0, 4'h4, 1'b0, 4'h1, 4'h3, 12'h002), 4'h0, ct(6'b100000, 4'h2), 4'h1, 4'h2, 4'h3, 4'h1, 4'h2);
    v[19] = mkv(alu(4'hB, 1'b0, 4'h4, 1'b0, 4'h1, 4'h3, 12'h002), 4'h8, ct(6'b100000, 4'h2), 4'h1, 4'h2, 4'h3, 4'h1, 4'h2);
    v[20] = mkv(alu(4'h8, 1'b0, 4'h4, 1'b0, 4'h1, 4'h3, 12'h002), 4'h6, ct(6'b000000, 4'h0), 4'h1, 4'h2, 4'h3, 4'h1, 4'h2);
    v[21] = mkv(alu(4'hA, 1'b0, 4'h4, 1'b0, 4'h1, 4'h3, 12'h002), 4'h9, ct(6'b100000, 4'h2), 4'h1, 4'h2, 4'h3, 4'h1, 4'h2);
    v[22] = mkv(alu(4'h1, 1'b0, 4'h4, 1'b0, 4'h1, 4'h3, 12'h002), 4'h4, ct(6'b000000, 4'h0), 4'h1, 4'h2, 4'h3, 4'h1, 4'h2);
    v[23] = mkv(mem(4'h2, 1'b1, 4'h9, 4'h8, 12'h004), 4'h0, ct(6'b000000, 4'h0), 4'h9, 4'h4, 4'h8, 4'h9, 4'h4);

    {io.in_valid, io.pc_in, io.instr, io.status, io.stall_in, io.flush} = '0;
    {io.wb_en, io.wb_dest, io.wb_data, io.exe_wb_en, io.mem_wb_en, io.exe_dest, io.mem_dest} = '0;
    {io2.in_valid, io2.pc_in, io2.instr, io2.status, io2.stall_in, io2.flush} = '0;
    {io2.wb_en, io2.wb_dest, io2.wb_data, io2.exe_wb_en, io2.mem_wb_en, io2.exe_dest, io2.mem_dest} = '0;
    {rf_we, rf_wa, rf_wd, rf_ra1, rf_ra2} = '0;

    // reset
    tick();
    tick();
    chk("reset", {ctl1(), io.val_rn_o, io.val_rm_o, io.dest_o, io.src1_o, io.src2_o,
                  io.shift_op_o, io.imm24_o, io.pc_o}, '0);
    chk("reset2", {io2.out_valid, io2.val_rn_o, io2.pc_o}, '0);
    rst = 1'b0;
    rf_ra1 = 5'd31;
    #1;
    chk("rf R31 reset", {rf_rd1, rf_rd2}, {16'd31, 16'd0});

    // decode table
    for (int i = 0; i < NV; i++) begin
      pc = 32'h100 + 32'(4 * i);
      io.in_valid = 1'b1;
      io.instr    = v[i].instr;
      io.status   = v[i].status;
      io.pc_in    = pc;
      #1;
      chk($sformatf("hz vec%0d", i), 160'(io.hazard_o), 160'(0));
      tick();
      chk($sformatf("ctl vec%0d", i),
          {ctl1(), io.val_rn_o, io.val_rm_o, io.dest_o, io.src1_o, io.src2_o},
          {v[i].ctl, 32'(v[i].rn), 32'(v[i].rm), v[i].d, v[i].s1, v[i].s2});
      chk($sformatf("fld vec%0d", i), {io.shift_op_o, io.imm24_o, io.pc_o},
          {v[i].instr[11:0], v[i].instr[23:0], pc});
    end

    // RAW hazard: bubble, then load once EXE no longer writes R1
    io.status = 4'h0;
    io.exe_dest = 4'h1; io.exe_wb_en = 1'b1;
    hz("hz sub exe", alu(4'hE, 1'b0, 4'h2, 1'b0, 4'h1, 4'h4, 12'h002), 1'b1);
    tick();
    chk("hz bubble", 160'(ctl1()), 160'(0));
    io.exe_wb_en = 1'b0;
    #1;
    chk("hz clear", 160'(io.hazard_o), 160'(0));
    tick();
    chk("hz sub load", {ctl1(), io.dest_o}, {ct(6'b100000, 4'h4), 4'h4});

    io.mem_dest = 4'h2; io.mem_wb_en = 1'b1;
    hz("hz mem src2", alu(4'hE, 1'b0, 4'h2, 1'b0, 4'h1, 4'h4, 12'h002), 1'b1);
    hz("hz imm no src2", alu(4'hE, 1'b1, 4'h2, 1'b0, 4'h1, 4'h4, 12'h002), 1'b0);
    hz("hz mov reg", alu(4'hE, 1'b0, 4'hD, 1'b0, 4'h0, 4'h5, 12'h002), 1'b1);
    io.mem_wb_en = 1'b0; io.exe_wb_en = 1'b1;
    hz("hz mov no src1", alu(4'hE, 1'b1, 4'hD, 1'b0, 4'h1, 4'h5, 12'h003), 1'b0);
    hz("hz branch", br(4'hE, 24'h010000), 1'b0);
    hz("hz cond fail", alu(4'h0, 1'b0, 4'h2, 1'b0, 4'h1, 4'h4, 12'h002), 1'b0);
    hz("hz str src2", mem(4'hE, 1'b0, 4'h3, 4'h1, 12'h000), 1'b1);
    hz("hz ldr one src", mem(4'hE, 1'b1, 4'h3, 4'h1, 12'h001), 1'b0);
    io.in_valid = 1'b0;
    hz("hz invalid", alu(4'hE, 1'b0, 4'h2, 1'b0, 4'h1, 4'h4, 12'h002), 1'b0);
    io.in_valid = 1'b1; io.exe_wb_en = 1'b0;

    // write-back bypass into the read of R5, then the stored value
    io.wb_en = 1'b1; io.wb_dest = 4'h5; io.wb_data = 32'hDEAD;
    io.instr = alu(4'hE, 1'b0, 4'h4, 1'b0, 4'h5, 4'h3, 12'h002);
    tick();
    chk("bypass rn", {io.val_rn_o, io.val_rm_o}, {32'hDEAD, 32'd2});
    io.wb_en = 1'b0;
    io.instr = alu(4'hE, 1'b0, 4'h4, 1'b0, 4'h2, 4'h3, 12'h005);
    tick();
    chk("stored rm", 160'(io.val_rm_o), 160'(32'hDEAD));

    // stall holds; RF write still lands
    io.instr = add312; io.pc_in = 32'h200;
    tick();
    chk("pre-stall", {ctl1(), io.val_rn_o, io.val_rm_o, io.dest_o, io.pc_o},
        {ct(6'b100000, 4'h2), 32'd1, 32'd2, 4'd3, 32'h200});
    io.stall_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      case (k)
        0: io.instr = alu(4'hE, 1'b1, 4'hD, 1'b0, 4'h0, 4'h4, 12'h005);
        1: begin
          io.instr = mem(4'hE, 1'b1, 4'h9, 4'h8, 12'h004);
          io.wb_en = 1'b1; io.wb_dest = 4'h9; io.wb_data = 32'h99;
        end
        2: io.instr = mem(4'hE, 1'b0, 4'h2, 4'h7, 12'h000);
        default: begin
          io.instr = alu(4'hE, 1'b0, 4'h2, 1'b0, 4'h1, 4'h4, 12'h002);
          io.exe_dest = 4'h1; io.exe_wb_en = 1'b1;
        end
      endcase
      io.pc_in = 32'h300 + 32'(4 * k);
      tick();
      io.wb_en = 1'b0;
      chk($sformatf("stall%0d", k), {ctl1(), io.val_rn_o, io.val_rm_o, io.dest_o, io.pc_o},
          {ct(6'b100000, 4'h2), 32'd1, 32'd2, 4'd3, 32'h200});
    end
    io.exe_wb_en = 1'b0;
    io.instr = add312;
    io.flush = 1'b1;
    tick();
    chk("flush+stall", 160'(ctl1()), 160'(0));
    io.flush = 1'b0; io.stall_in = 1'b0;
    tick();
    chk("reload", 160'(ctl1()), 160'(ct(6'b100000, 4'h2)));
    io.flush = 1'b1;
    tick();
    chk("flush", 160'(ctl1()), 160'(0));
    io.flush = 1'b0;
    io.instr = alu(4'hE, 1'b0, 4'h4, 1'b0, 4'h9, 4'h3, 12'h002);
    tick();
    chk("stall wr", {io.out_valid, io.val_rn_o}, {1'b1, 32'h99});

    // wide-parameter instance: R15/R14 in 16 bits
    io2.in_valid = 1'b1; io2.pc_in = 16'h1234;
    io2.instr = alu(4'hE, 1'b0, 4'h4, 1'b0, 4'hF, 4'h3, 12'h00E);
    tick();
    chk("dut2 read", {io2.out_valid, io2.val_rn_o, io2.val_rm_o, io2.pc_o, io2.dest_o},
        {1'b1, 16'd15, 16'd14, 16'h1234, 5'd3});

    // no-bypass register file: same-cycle read returns the old value
    rf_we = 1'b1; rf_wa = 5'd31; rf_wd = 16'hBEEF;
    #1;
    chk("rf nobypass", 160'(rf_rd1), 160'(16'd31));
    tick();
    rf_we = 1'b0;
    chk("rf written", 160'(rf_rd1), 160'(16'hBEEF));

    // reset restores register-file contents
    rst = 1'b1;
    tick();
    rst = 1'b0;
    io.instr = alu(4'hE, 1'b0, 4'h4, 1'b0, 4'h5, 4'h3, 12'h009);
    tick();
    chk("rf re-reset", {io.val_rn_o, io.val_rm_o}, {32'd5, 32'd9});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/id_stage_pipelined.md
Name: id_stage_pipelined

Overview:
- Parametrised ARM decode stage for the five-stage core.
- Decodes the instruction, evaluates the condition field against NZCV, reads the register file, and detects RAW hazards against EXE/MEM.
- Results are registered into an integrated ID/EX pipeline register with stall, bubble and flush control.
- Replaces the bare combinational ID stage plus separate ID/EX register pair.

Parameters:
- DATA_W, 32, width of datapath, PC and register entries.
- REG_AW, 4, register address width; register file holds 2**REG_AW entries.
- WB_BYPASS, 1, 1 = a write-back to a source register in the same cycle is forwarded to the read value.

Ports:
- clk  in  1  core clock, all state on rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  IF/ID holds a real instruction.
- pc_in  in  DATA_W  PC+4 of the instruction.
- instr  in  32  instruction word.
- status  in  4  NZCV flags {N,Z,C,V} = bits [3:0].
- stall_in  in  1  downstream freeze; hold ID/EX contents.
- flush  in  1  branch taken; kill the instruction entering ID/EX.
- wb_en  in  1  write-back enable.
- wb_dest  in  REG_AW  write-back register.
- wb_data  in  DATA_W  write-back value.
- exe_wb_en, mem_wb_en  in  1 each  WB enables of instructions in EXE and MEM.
- exe_dest, mem_dest  in  REG_AW each  destinations in EXE and MEM.
- hazard_o  out  1  combinational; IF and PC must hold, ID/EX takes a bubble.
- out_valid  out  1  ID/EX holds a live instruction.
- wb_en_o, mem_r_en_o, mem_w_en_o, b_o, s_o, imm_o  out  1 each  registered controls.
- exe_cmd_o  out  4  ALU command.
- val_rn_o, val_rm_o  out  DATA_W  operand values.
- dest_o, src1_o, src2_o  out  REG_AW  register indices (src1/src2 feed the forwarding unit).
- shift_op_o  out  12  instr[11:0].
- imm24_o  out  24  instr[23:0].
- pc_o  out  DATA_W  registered pc_in.

Behaviour:
- Reset: every ID/EX output is 0. Register file entry i resets to value i.
- Register file: write on posedge when wb_en. Reads are combinational.
  - src1 = instr[19:16].
  - src2 = instr[15:12] for STR, otherwise instr[3:0].
  - With WB_BYPASS=1, wb_en && wb_dest==src returns wb_data; otherwise the old value is returned.
- Condition check on instr[31:28], standard ARM encodings 0–14. Code 15 always fails.
- Decode (mode = instr[27:26], op = instr[24:21], S = instr[20]):
  - mode 00: MOV→1, MVN→9, ADD→2, ADC→3, SUB→4, SBC→5, AND→6, ORR→7, EOR→8, CMP→4 (no WB), TST→6 (no WB). Undefined op → NOP with all controls 0.
  - mode 01: S=1 is LDR (cmd 2, mem_r, wb). S=0 is STR (cmd 2, mem_w).
  - mode 10: b=1, cmd 0.
  - s_o = S for mode 00 only. dest = instr[15:12].
- Condition fail: wb_en, mem_r_en, mem_w_en, b, s and exe_cmd are forced to 0. out_valid is still loaded with in_valid.
- Hazard (combinational):
  - hazard_o = in_valid && cond_pass && (RAW on src1 || RAW on src2 when the instruction uses two sources).
  - RAW means src == exe_dest with exe_wb_en, or src == mem_dest with mem_wb_en.
  - src1 is used by every mode-00 op except MOV/MVN, and by LDR/STR.
  - The instruction uses two sources when it is STR, or mode 00 with I = instr[25] = 0.
  - Branches are never hazards.
- ID/EX update priority each edge:
  1. rst.
  2. flush: load a bubble.
  3. stall_in: hold all outputs.
  4. hazard_o: load a bubble.
  5. Otherwise load the decoded values.
- A bubble sets out_valid=0 and all control outputs to 0. Data fields may hold any value.
- Latency: instruction to ID/EX outputs = 1 cycle.
- Register-file writes proceed during stall_in, flush and hazard.

Decomposition:
- Package arm_pkg holds:
  - mode constants;
  - opcode constants;
  - EXE_CMD encodings;
  - condition-code enum;
  - the NZCV index constants.
- One sub-module, reg_file (parametrised by DATA_W, REG_AW and WB_BYPASS).
- Condition check and decode stay inline as functions in arm_pkg.

Test Plan:
- Reset, then ADD R3,R1,R2 with cond AL, in_valid=1 → next cycle: exe_cmd_o=2, wb_en_o=1, val_rn_o=1, val_rm_o=2, dest_o=3, out_valid=1.
- EQ-conditioned MOV with status Z=0 → out_valid=1 and all controls 0. Same instruction with Z=1 → wb_en_o=1, exe_cmd_o=1.
- exe_dest=1, exe_wb_en=1, then SUB R4,R1,R2 → hazard_o=1 and a bubble is loaded. When exe_wb_en drops, the SUB is loaded the following cycle.
- wb_en=1, wb_dest=5, wb_data=0xDEAD with ADD reading R5 in the same cycle → val_rn_o=0xDEAD (WB_BYPASS=1). The later read also returns 0xDEAD.
- stall_in=1 for 3 cycles with varying instr → outputs are frozen. Asserting flush together with stall_in → bubble (flush wins).
- STR R7,[R2] with R7=7 → src2_o=7, val_rm_o=7, mem_w_en_o=1, wb_en_o=0. With REG_AW=5 and DATA_W=16, the reset read of R31 returns 31.
